// File: rtl/branch_resolve_unit_pkg.sv
// Shared pipeline definitions: branch funct3 encodings, redirect FSM states and
// opcode classes shared with the decoder.
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  typedef enum logic [1:0] {
    StIdle,
    StRedirect,
    StFlush
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational RV32I branch condition from funct3 and the flags of rs1 - rs2.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       z_i,
  input  logic       n_i,
  input  logic       c_i,
  input  logic       v_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    unique case (funct3_i)
      F3Beq:   taken_o = z_i;
      F3Bne:   taken_o = ~z_i;
      F3Blt:   taken_o = n_i ^ v_i;
      F3Bge:   taken_o = ~(n_i ^ v_i);
      F3Bltu:  taken_o = ~c_i;
      F3Bgeu:  taken_o = c_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates the condition, forms the target and
// drives a registered redirect handshake toward fetch plus pipeline flush strobes.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      alu_result,
  input  logic             Z,
  input  logic             N,
  input  logic             C,
  input  logic             V,
  input  logic             redir_ready,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] FlushLast = 3'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misalign_q, misalign_d;

  logic        cond_taken;
  logic        taken;
  logic [31:0] target;

  branch_cond_eval u_cond (
    .funct3_i (ex_funct3),
    .z_i      (Z),
    .n_i      (N),
    .c_i      (C),
    .v_i      (V),
    .taken_o  (cond_taken)
  );

  // JALR clears bit 0 of the ALU sum; branch and JAL share the PC-relative adder.
  always_comb begin
    taken = ex_valid & (ex_jal | ex_jalr | (ex_branch & cond_taken));
    if (ex_jalr) begin
      target = alu_result & 32'hFFFF_FFFE;
    end else begin
      target = ex_pc + ex_imm;
    end
  end

  always_comb begin
    state_d     = state_q;
    redir_pc_d  = redir_pc_q;
    flush_cnt_d = flush_cnt_q;
    cnt_d       = cnt_q;
    misalign_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (taken) begin
          redir_pc_d = target;
          if (target[1]) begin
            misalign_d = 1'b1;
          end else begin
            state_d = StRedirect;
          end
        end
      end
      StRedirect: begin
        if (redir_ready) begin
          state_d     = StFlush;
          flush_cnt_d = FlushLast;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      StFlush: begin
        if (flush_cnt_q == 3'd0) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      redir_pc_q  <= 32'h0;
      flush_cnt_q <= 3'd0;
      cnt_q       <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      redir_pc_q  <= redir_pc_d;
      flush_cnt_q <= flush_cnt_d;
      cnt_q       <= cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  assign redir_valid = (state_q == StRedirect);
  assign redir_pc    = redir_pc_q;
  assign flush_if_id = (state_q != StIdle);
  assign flush_id_ex = (state_q != StIdle);
  assign stall       = (state_q != StIdle);
  assign misalign    = misalign_q;
  assign taken_cnt   = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit built with FLUSH_CYCLES = 2 and CNT_W = 4.
module tb_branch_resolve_unit;

  localparam int unsigned FlushCycles = 2;
  localparam int unsigned CntW        = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, ex_branch, ex_jal, ex_jalr;
  logic [2:0]      ex_funct3;
  logic [31:0]     ex_pc, ex_imm, alu_result;
  logic            Z, N, C, V;
  logic            redir_ready;
  logic            redir_valid;
  logic [31:0]     redir_pc;
  logic            flush_if_id, flush_id_ex, stall, misalign;
  logic [CntW-1:0] taken_cnt;

  int checks = 0;
  int errors = 0;
  logic [CntW-1:0] exp_cnt = '0;

  branch_resolve_unit #(
    .FLUSH_CYCLES (FlushCycles),
    .CNT_W        (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_jal      (ex_jal),
    .ex_jalr     (ex_jalr),
    .ex_funct3   (ex_funct3),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .alu_result  (alu_result),
    .Z           (Z),
    .N           (N),
    .C           (C),
    .V           (V),
    .redir_ready (redir_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .stall       (stall),
    .misalign    (misalign),
    .taken_cnt   (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
    ex_jal    = 1'b0;
    ex_jalr   = 1'b0;
  endtask

  task automatic drive_jal(input logic [31:0] pc, input logic [31:0] imm);
    clear_ex();
    ex_valid = 1'b1;
    ex_jal   = 1'b1;
    ex_pc    = pc;
    ex_imm   = imm;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (stall && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: stall=%b after %0d cycles, required 0", stall, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_ex();
    ex_funct3 = 3'b000; ex_pc = '0; ex_imm = '0; alu_result = '0;
    Z = 0; N = 0; C = 0; V = 0; redir_ready = 1'b0;
    step();
    checks++;
    if ({redir_valid, redir_pc, flush_if_id, flush_id_ex, stall, misalign, taken_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b pc=%h fl=%b%b stall=%b mis=%b cnt=%0d, required all 0",
               redir_valid, redir_pc, flush_if_id, flush_id_ex, stall, misalign, taken_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_beq();
    int n = 0;
    clear_ex();
    ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b000;
    ex_pc = 32'h100; ex_imm = 32'h20; Z = 1'b1; redir_ready = 1'b1;
    step();
    clear_ex();
    checks++;
    if (redir_valid !== 1'b1 || redir_pc !== 32'h120) begin
      errors++;
      $display("FAIL beq_redirect: valid=%b pc=%h, required 1 00000120", redir_valid, redir_pc);
    end
    checks++;
    if (flush_id_ex !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL beq_flush_stall: flush_id_ex=%b stall=%b, required 1 1", flush_id_ex, stall);
    end
    while (flush_if_id && n < 12) begin
      n++;
      step();
    end
    checks++;
    if (n != 1 + FlushCycles) begin
      errors++;
      $display("FAIL beq_flush_len: %0d cycles, required %0d", n, 1 + FlushCycles);
    end
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (taken_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL beq_count: cnt=%0d, required %0d", taken_cnt, exp_cnt);
    end
  endtask

  // {funct3, Z, N, C, V, expected_taken}
  task automatic test_conditions();
    logic [7:0] vecs [9] = '{8'b10001101, 8'b11001100, 8'b11101101, 8'b10101100,
                             8'b00001100, 8'b00101101, 8'b01010000, 8'b10001010,
                             8'b10101011};
    for (int i = 0; i < 9; i++) begin
      logic [7:0] v;
      v = vecs[i];
      clear_ex();
      ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = v[7:5];
      Z = v[4]; N = v[3]; C = v[2]; V = v[1];
      ex_pc = 32'h300; ex_imm = 32'h10; redir_ready = 1'b1;
      step();
      clear_ex();
      checks++;
      if (redir_valid !== v[0]) begin
        errors++;
        $display("FAIL cond_%0d: funct3=%b flags=%b valid=%b, required %b",
                 i, v[7:5], v[4:1], redir_valid, v[0]);
      end
      if (v[0]) exp_cnt = exp_cnt + 1'b1;
      wait_idle();
    end
    // jalr wins over jal
    drive_jal(32'h500, 32'h100);
    ex_jalr = 1'b1; alu_result = 32'h5000;
    step();
    clear_ex();
    checks++;
    if (redir_valid !== 1'b1 || redir_pc !== 32'h5000) begin
      errors++;
      $display("FAIL jalr_priority: valid=%b pc=%h, required 1 00005000", redir_valid, redir_pc);
    end
    exp_cnt = exp_cnt + 1'b1;
    wait_idle();
    checks++;
    if (taken_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL cond_count: cnt=%0d, required %0d", taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_misalign();
    clear_ex();
    ex_valid = 1'b1; ex_jalr = 1'b1; alu_result = 32'h2003;
    ex_pc = 32'h1000; ex_imm = 32'h0; redir_ready = 1'b1;
    step();
    clear_ex();
    checks++;
    if (misalign !== 1'b1 || redir_pc !== 32'h2002) begin
      errors++;
      $display("FAIL misalign_pulse: mis=%b pc=%h, required 1 00002002", misalign, redir_pc);
    end
    checks++;
    if (redir_valid !== 1'b0 || stall !== 1'b0 || flush_if_id !== 1'b0) begin
      errors++;
      $display("FAIL misalign_noredir: valid=%b stall=%b flush=%b, required 0 0 0",
               redir_valid, stall, flush_if_id);
    end
    step();
    checks++;
    if (misalign !== 1'b0 || taken_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL misalign_after: mis=%b cnt=%0d, required 0 %0d", misalign, taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back_wait();
    drive_jal(32'h400, 32'h80);
    redir_ready = 1'b0;
    step();
    // A second transfer presented while busy must be dropped.
    drive_jal(32'h800, 32'h40);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (redir_valid !== 1'b1 || redir_pc !== 32'h480 || stall !== 1'b1 ||
          taken_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL wait_hold_%0d: valid=%b pc=%h stall=%b cnt=%0d, required 1 00000480 1 %0d",
                 i, redir_valid, redir_pc, stall, taken_cnt, exp_cnt);
      end
      step();
    end
    clear_ex();
    redir_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (redir_valid !== 1'b0 || taken_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL wait_handshake: valid=%b cnt=%0d, required 0 %0d", redir_valid, taken_cnt, exp_cnt);
    end
    wait_idle();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (redir_valid !== 1'b0 || taken_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL wait_not_queued: valid=%b cnt=%0d, required 0 %0d", redir_valid, taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive_jal(32'h600, 32'h20);
    redir_ready = 1'b0;
    step();
    clear_ex();
    checks++;
    if (redir_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: valid=%b, required 1", redir_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({redir_valid, redir_pc, flush_if_id, flush_id_ex, stall, misalign, taken_cnt} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b pc=%h stall=%b cnt=%0d, required all 0",
               redir_valid, redir_pc, stall, taken_cnt);
    end
    exp_cnt = '0;
    redir_ready = 1'b1;
    step();
    rst = 1'b0;
    clear_ex();
    ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b001; Z = 1'b0;
    ex_pc = 32'h200; ex_imm = 32'hFFFF_FFF0;
    step();
    clear_ex();
    checks++;
    if (redir_valid !== 1'b1 || redir_pc !== 32'h1F0) begin
      errors++;
      $display("FAIL rstmid_bne: valid=%b pc=%h, required 1 000001f0", redir_valid, redir_pc);
    end
    exp_cnt = exp_cnt + 1'b1;
    wait_idle();
  endtask

  task automatic test_wrap();
    int n = 0;
    redir_ready = 1'b1;
    while (exp_cnt != '1 && n < 20) begin
      drive_jal(32'h40, 32'h4);
      step();
      clear_ex();
      wait_idle();
      exp_cnt = exp_cnt + 1'b1;
      n++;
    end
    checks++;
    if (taken_cnt !== 4'hF) begin
      errors++;
      $display("FAIL wrap_preload: cnt=%0d, required 15", taken_cnt);
    end
    drive_jal(32'h40, 32'h4);
    step();
    clear_ex();
    wait_idle();
    checks++;
    if (taken_cnt !== 4'h0) begin
      errors++;
      $display("FAIL wrap_zero: cnt=%0d, required 0", taken_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_conditions();
    test_misalign();
    test_back_to_back_wait();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
